// File: rtl/key_entry_buffer.sv
// Keypad entry buffer: edge-detected digit/delete/enter/clear keys feeding a shift buffer.
// Optional inactivity timeout is built when KEY_ENTRY_TIMEOUT_EN is defined.
module key_entry_buffer #(
  parameter int KEY_WIDTH      = 4,
  parameter int MAX_KEYS       = 6,
  parameter int COUNT_WIDTH    = 3,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int TIMER_WIDTH    = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          keyPress,
  input  logic [KEY_WIDTH-1:0]          keyCode,
  input  logic                          deletePress,
  input  logic                          enterPress,
  input  logic                          clearPress,
  output logic [KEY_WIDTH*MAX_KEYS-1:0] keyValueStore,
  output logic [COUNT_WIDTH-1:0]        keyNumbersStore,
  output logic [KEY_WIDTH*MAX_KEYS-1:0] entryValue,
  output logic [COUNT_WIDTH-1:0]        entryLength,
  output logic                          entryValid,
  output logic                          timeoutFlag,
  output logic                          overflowFlag,
  output logic                          entryActive
);

  localparam int BufW = KEY_WIDTH * MAX_KEYS;

  typedef enum logic {IDLE, ENTRY} state_t;

  state_t state, stateNext;

  logic                 keyCur, keyPrev;
  logic                 delCur, delPrev;
  logic                 entCur, entPrev;
  logic                 clrCur, clrPrev;
  logic [KEY_WIDTH-1:0] codeCur;

  logic                   clrGo, entGo, delGo, keyGo;
  logic [BufW-1:0]        bufNext, valNext;
  logic [COUNT_WIDTH-1:0] cntNext, lenNext;
  logic                   validNext, ovfNext;
  logic                   tcHit;

  // Mask lower-priority events so exactly one (or none) acts per cycle
  assign clrGo = clrCur & ~clrPrev;
  assign entGo = entCur & ~entPrev & ~clrGo;
  assign delGo = delCur & ~delPrev & ~clrGo & ~entGo;
  assign keyGo = keyCur & ~keyPrev & ~clrGo & ~entGo & ~delGo;

  assign entryActive = (state == ENTRY);

`ifdef KEY_ENTRY_TIMEOUT_EN
  logic [TIMER_WIDTH-1:0] timer;
  logic                   anyEvt;

  assign anyEvt = clrGo | entGo | delGo | keyGo;
  assign tcHit  = (state == ENTRY) &&
                  (timer == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer       <= '0;
      timeoutFlag <= 1'b0;
    end else begin
      timeoutFlag <= tcHit & ~anyEvt;
      if (stateNext == IDLE || anyEvt || tcHit)
        timer <= '0;
      else
        timer <= timer + TIMER_WIDTH'(1);
    end
  end
`else
  assign tcHit       = 1'b0;
  assign timeoutFlag = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      keyCur          <= 1'b0;
      keyPrev         <= 1'b0;
      delCur          <= 1'b0;
      delPrev         <= 1'b0;
      entCur          <= 1'b0;
      entPrev         <= 1'b0;
      clrCur          <= 1'b0;
      clrPrev         <= 1'b0;
      codeCur         <= '0;
      state           <= IDLE;
      keyValueStore   <= '0;
      keyNumbersStore <= '0;
      entryValue      <= '0;
      entryLength     <= '0;
      entryValid      <= 1'b0;
      overflowFlag    <= 1'b0;
    end else begin
      keyCur          <= keyPress;
      keyPrev         <= keyCur;
      delCur          <= deletePress;
      delPrev         <= delCur;
      entCur          <= enterPress;
      entPrev         <= entCur;
      clrCur          <= clearPress;
      clrPrev         <= clrCur;
      codeCur         <= keyCode;
      state           <= stateNext;
      keyValueStore   <= bufNext;
      keyNumbersStore <= cntNext;
      entryValue      <= valNext;
      entryLength     <= lenNext;
      entryValid      <= validNext;
      overflowFlag    <= ovfNext;
    end
  end

  always_comb begin
    stateNext = state;
    bufNext   = keyValueStore;
    cntNext   = keyNumbersStore;
    valNext   = entryValue;
    lenNext   = entryLength;
    validNext = 1'b0;
    ovfNext   = 1'b0;
    unique case (1'b1)
      clrGo: begin
        bufNext   = '0;
        cntNext   = '0;
        stateNext = IDLE;
      end
      entGo: begin
        if (state == ENTRY) begin
          valNext   = keyValueStore;
          lenNext   = keyNumbersStore;
          validNext = 1'b1;
          bufNext   = '0;
          cntNext   = '0;
          stateNext = IDLE;
        end
      end
      delGo: begin
        if (keyNumbersStore != '0) begin
          bufNext = keyValueStore >> KEY_WIDTH;
          cntNext = keyNumbersStore - COUNT_WIDTH'(1);
          if (keyNumbersStore == COUNT_WIDTH'(1))
            stateNext = IDLE;
        end
      end
      keyGo: begin
        if (keyNumbersStore < COUNT_WIDTH'(MAX_KEYS)) begin
          bufNext   = (keyValueStore << KEY_WIDTH) | BufW'(codeCur);
          cntNext   = keyNumbersStore + COUNT_WIDTH'(1);
          stateNext = ENTRY;
        end else begin
          ovfNext = 1'b1;
        end
      end
      default: begin
        if (tcHit) begin
          bufNext   = '0;
          cntNext   = '0;
          stateNext = IDLE;
        end
      end
    endcase
  end

endmodule

// File: doc/key_entry_buffer.md
# key_entry_buffer

Synchronous, parametrised keypad entry buffer for the digital lock. It edge-detects digit, delete, enter and clear key levels, then shifts digits into a buffer of up to MAX_KEYS codes. It supports backspace, an explicit enter-to-submit with a held snapshot of the entry, overflow rejection and an inactivity timeout. It sits between the keypad scanner and the lock control state machine, which consumes the submit and timeout pulses.

## Interface
- KEY_WIDTH, 4: bits per key code
- MAX_KEYS, 6: maximum digits per entry (≥1)
- COUNT_WIDTH, 3: width of the digit count; must hold MAX_KEYS
- TIMEOUT_CYCLES, 50_000_000: inactivity timeout in clock cycles (1 s at 50 MHz); ≥2
- TIMER_WIDTH, 32: timeout counter width; must hold TIMEOUT_CYCLES-1

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- keyPress  in  1  digit key level, high while held
- keyCode  in  KEY_WIDTH  digit code, stable while keyPress high
- deletePress  in  1  backspace key level
- enterPress  in  1  submit key level
- clearPress  in  1  clear key level
- keyValueStore  out  KEY_WIDTH*MAX_KEYS  live buffer, newest digit in LSBs, unused upper slots zero
- keyNumbersStore  out  COUNT_WIDTH  live digit count, 0..MAX_KEYS
- entryValue  out  KEY_WIDTH*MAX_KEYS  snapshot of the buffer at the last submit
- entryLength  out  COUNT_WIDTH  digit count at the last submit
- entryValid  out  1  one-cycle submit pulse
- timeoutFlag  out  1  one-cycle timeout pulse
- overflowFlag  out  1  one-cycle pulse when a digit is rejected because the buffer is full
- entryActive  out  1  high while state is ENTRY

## Operation
- Each key input goes through a two-stage register (cur, prev). Event = cur & ~prev, so one event per press regardless of hold time.
- Event priority when several occur in the same cycle: clear > enter > delete > digit. Only the highest-priority event acts; the others are discarded.
- State machine with two states, IDLE and ENTRY. In IDLE the count is 0; in ENTRY the count is ≥1.
  - Digit, count < MAX_KEYS: keyValueStore ← (keyValueStore << KEY_WIDTH) | keyCode (the registered copy); count+1; go to ENTRY.
  - Digit, count == MAX_KEYS: buffer unchanged; overflowFlag pulses. No wrap.
  - Delete, count ≥1: keyValueStore ← keyValueStore >> KEY_WIDTH with a zero fill; count−1; go to IDLE when the count reaches 0. Delete with count 0 is ignored.
  - Enter, count ≥1: entryValue/entryLength ← buffer/count; entryValid pulses; buffer and count cleared; go to IDLE. Enter in IDLE is ignored (no pulse).
  - Clear: buffer and count cleared; go to IDLE; no pulse.
  - Timeout (ENTRY only): buffer and count cleared; timeoutFlag pulses; go to IDLE. entryValue is not touched.
- The timeout counter is held at 0 in IDLE and cleared on every accepted event. In ENTRY it increments each cycle. When it equals TIMEOUT_CYCLES−1, timeout fires and the counter returns to 0.
- An accepted event in the same cycle as a timeout terminal count wins: the event executes, no timeout fires, and the counter clears.
- entryValue/entryLength hold until the next submit.

## Timing
- Reset: all outputs 0, state IDLE, edge registers 0, timer 0. Assertion mid-entry discards everything immediately (asynchronously). A key already held when reset releases produces one event, because prev starts at 0.
- Latency: a level first sampled high at edge k is registered into cur at k. The buffer, count and pulses update at edge k+1.
- All pulses are exactly one cycle wide and registered. entryValid and the cleared buffer appear on the same edge.
- Timeout: after the last accepted event at edge e, timeoutFlag is high in the cycle following edge e+TIMEOUT_CYCLES.

## Configuration
- KEY_ENTRY_TIMEOUT_EN defined: timeout counter and timeout transition are present, as described above.
- Not defined: no timer logic is synthesised, timeoutFlag is tied to 0, and an entry persists until enter, clear or reset. TIMEOUT_CYCLES and TIMER_WIDTH are accepted but unused.

## Test plan
Bench parameters: MAX_KEYS=6, TIMEOUT_CYCLES=500.
- Press 1,2,3,4, then enter → entryValid for 1 cycle, entryValue=24'h001234, entryLength=4, keyNumbersStore=0.
- Press 9,8,7, delete, 5 → keyValueStore=24'h000985, count=3. A delete with count 0 leaves everything at 0 with no pulses.
- Press seven digits 1..7 → after the 6th, buffer=24'h123456. The 7th raises overflowFlag for 1 cycle, buffer unchanged, and enter then yields entryLength=6.
- With the macro defined, press 3, then idle → timeoutFlag high exactly 500 cycles after the digit's update edge, buffer=0. A digit at cycle 499 suppresses the timeout and restarts the count. Without the macro, no timeoutFlag after 2000 cycles.
- Digit and clear edges in the same cycle → clear wins, count=0. Enter and delete in the same cycle with count 2 → submit with entryLength=2.
- Assert reset mid-entry (count=4) → all outputs 0 within the same cycle. Release reset while keyPress is held → exactly one digit stored.
